dmem_stage: RTL and testbench

Parametrised data-memory stage for the RISC-V pipeline. It supports byte-lane stores and sign- or zero-extending loads over a word array of any depth and XLEN. A configurable number of wait states is sequenced by a request/response FSM, and misaligned or out-of-range accesses are flagged. It sits between the execute/memory pipeline register and writeback, returning a destination tag with every response so the pipeline can retire loads out of a multi-cycle memory.

---
 rtl/dmem_stage.sv | 228 ++++++++++++++++++++++
 tb/tb_dmem_stage.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_stage.sv
// Data-memory stage: byte-lane stores, extending loads, wait-state FSM, tagged responses.
// Optional build macro DMEM_ACCESS_CHECK_EN: flag misaligned/out-of-range accesses instead of wrapping.

typedef enum logic [3:0] {
    OP_LB  = 4'h0,
    OP_LH  = 4'h1,
    OP_LW  = 4'h2,
    OP_LBU = 4'h4,
    OP_LHU = 4'h5,
    OP_SB  = 4'h8,
    OP_SH  = 4'h9,
    OP_SW  = 4'hA
} operation_e;

module dmem_stage #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned DEPTH       = 2048,
    parameter int unsigned WAIT_STATES = 0,
    parameter int unsigned TAG_W       = 5
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  operation_e       req_op_i,
    input  logic [XLEN-1:0]  req_addr_i,
    input  logic [XLEN-1:0]  req_wdata_i,
    input  logic [TAG_W-1:0] req_tag_i,
    input  logic             flush_i,
    output logic             resp_valid_o,
    output logic [XLEN-1:0]  resp_data_o,
    output logic [TAG_W-1:0] resp_tag_o,
    output logic [1:0]       resp_err_o,
    output logic             busy_o
);

    localparam int unsigned NB  = XLEN / 8;
    localparam int unsigned OFF = $clog2(NB);
    localparam int unsigned AW  = $clog2(DEPTH);
    localparam int unsigned CW  = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             accept;
    logic             enter_resp;
    logic             mem_we;

    operation_e       op_q, acc_op;
    logic [XLEN-1:0]  addr_q, wdata_q, acc_addr, acc_wdata;
    logic [TAG_W-1:0] tag_q, acc_tag;

    logic             is_load, is_store, is_signed;
    logic [1:0]       size_lg;
    logic [OFF-1:0]   lane_raw, lane;
    logic [AW-1:0]    word_idx;
    logic [1:0]       err;
    logic [XLEN-1:0]  rd_word, rd_shift, load_val, wdata_sh;
    logic [NB-1:0]    be_base, be;

    logic [XLEN-1:0]  resp_data_d;

    logic [XLEN-1:0]  mem [DEPTH];

    assign req_ready_o = (state_q == S_IDLE) || (state_q == S_RESP);

    // With zero wait states the access happens on the accept edge, so use the live request.
    assign acc_op    = (state_q == S_WAIT) ? op_q    : req_op_i;
    assign acc_addr  = (state_q == S_WAIT) ? addr_q  : req_addr_i;
    assign acc_wdata = (state_q == S_WAIT) ? wdata_q : req_wdata_i;
    assign acc_tag   = (state_q == S_WAIT) ? tag_q   : req_tag_i;

    // State register
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        accept  = req_valid_i && req_ready_o && !flush_i;
        case (state_q)
            S_IDLE, S_RESP: begin
                if (accept) begin
                    state_d = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (flush_i) begin
                    state_d = S_IDLE;
                end else if (cnt_q == '0) begin
                    state_d = S_RESP;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Operation decode
    always_comb begin
        is_load   = 1'b0;
        is_store  = 1'b0;
        is_signed = 1'b0;
        size_lg   = 2'd0;
        case (acc_op)
            OP_LB:  begin is_load = 1'b1; is_signed = 1'b1; size_lg = 2'd0; end
            OP_LH:  begin is_load = 1'b1; is_signed = 1'b1; size_lg = 2'd1; end
            OP_LW:  begin is_load = 1'b1; is_signed = 1'b1; size_lg = 2'd2; end
            OP_LBU: begin is_load = 1'b1; size_lg = 2'd0; end
            OP_LHU: begin is_load = 1'b1; size_lg = 2'd1; end
            OP_SB:  begin is_store = 1'b1; size_lg = 2'd0; end
            OP_SH:  begin is_store = 1'b1; size_lg = 2'd1; end
            OP_SW:  begin is_store = 1'b1; size_lg = 2'd2; end
            default: ;
        endcase
    end

    assign lane_raw = acc_addr[OFF-1:0];
    assign word_idx = acc_addr[AW+OFF-1:OFF];

`ifdef DMEM_ACCESS_CHECK_EN
    localparam logic [63:0] MEM_BYTES = 64'(DEPTH) * 64'(NB);

    always_comb begin
        err = 2'b00;
        if (is_load || is_store) begin
            err[0] = ((size_lg == 2'd1) && lane_raw[0]) ||
                     ((size_lg == 2'd2) && (lane_raw[1:0] != 2'b00));
            err[1] = 64'(acc_addr) >= MEM_BYTES;
        end
    end
`else
    logic unused_addr;
    assign err         = 2'b00;
    assign unused_addr = ^acc_addr;
`endif

    // Lane alignment, byte enables and load extraction
    always_comb begin
        lane    = lane_raw;
        be_base = NB'(1);
        case (size_lg)
            2'd1:    begin lane = lane_raw & ~OFF'(1); be_base = NB'(3);  end
            2'd2:    begin lane = lane_raw & ~OFF'(3); be_base = NB'(15); end
            default: ;
        endcase
        be       = be_base << lane;
        wdata_sh = acc_wdata << {lane, 3'b000};
        rd_shift = rd_word >> {lane, 3'b000};
        case (size_lg)
            2'd0:    load_val = is_signed ? XLEN'(signed'(rd_shift[7:0]))  : XLEN'(rd_shift[7:0]);
            2'd1:    load_val = is_signed ? XLEN'(signed'(rd_shift[15:0])) : XLEN'(rd_shift[15:0]);
            default: load_val = XLEN'(signed'(rd_shift[31:0]));
        endcase
    end

    assign rd_word = mem[word_idx];

    // Counter, response and memory-enable next values
    always_comb begin
        cnt_d       = cnt_q;
        enter_resp  = (state_d == S_RESP);
        resp_data_d = '0;
        mem_we      = 1'b0;
        if (accept && (WAIT_STATES != 0)) begin
            cnt_d = CW'(WAIT_STATES - 1);
        end else if ((state_q == S_WAIT) && (cnt_q != '0)) begin
            cnt_d = cnt_q - CW'(1);
        end
        if (is_load && (err == 2'b00)) begin
            resp_data_d = load_val;
        end
        mem_we = rstn_i && enter_resp && is_store && (err == 2'b00);
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cnt_q        <= '0;
            op_q         <= OP_LB;
            addr_q       <= '0;
            wdata_q      <= '0;
            tag_q        <= '0;
            resp_valid_o <= 1'b0;
            resp_data_o  <= '0;
            resp_tag_o   <= '0;
            resp_err_o   <= 2'b00;
            busy_o       <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            resp_valid_o <= enter_resp;
            busy_o       <= (state_d != S_IDLE);
            if (accept) begin
                op_q    <= req_op_i;
                addr_q  <= req_addr_i;
                wdata_q <= req_wdata_i;
                tag_q   <= req_tag_i;
            end
            if (enter_resp) begin
                resp_data_o <= resp_data_d;
                resp_tag_o  <= acc_tag;
                resp_err_o  <= err;
            end
        end
    end

    // Word array is intentionally not reset
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            for (int b = 0; b < int'(NB); b++) begin
                if (be[b]) begin
                    mem[word_idx][b*8 +: 8] <= wdata_sh[b*8 +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_stage.sv
// Self-checking bench for dmem_stage: one instance with 0 wait states, one with 3.
module tb_dmem_stage;

    localparam int unsigned DEPTH = 256;
    localparam int NVEC = 18;

    typedef struct {
        operation_e  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        logic [1:0]  exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  tag;
        logic [1:0]  err;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstn;
    logic        req_valid [2];
    logic        flush     [2];
    operation_e  op        [2];
    logic [31:0] addr      [2];
    logic [31:0] wdata     [2];
    logic [4:0]  tag       [2];
    logic        ready     [2];
    logic        rv        [2];
    logic        busy      [2];
    logic [31:0] rdata     [2];
    logic [4:0]  rtag      [2];
    logic [1:0]  rerr      [2];

    int   cyc    = 0;
    int   n_cmp  = 0;
    int   n_fail = 0;
    exp_t sbq0[$];
    exp_t sbq1[$];
    vec_t tbl [NVEC];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_stage #(.XLEN(32), .DEPTH(DEPTH), .WAIT_STATES(0), .TAG_W(5)) u_dut0 (
        .clk_i(clk), .rstn_i(rstn),
        .req_valid_i(req_valid[0]), .req_ready_o(ready[0]), .req_op_i(op[0]),
        .req_addr_i(addr[0]), .req_wdata_i(wdata[0]), .req_tag_i(tag[0]),
        .flush_i(flush[0]),
        .resp_valid_o(rv[0]), .resp_data_o(rdata[0]), .resp_tag_o(rtag[0]),
        .resp_err_o(rerr[0]), .busy_o(busy[0])
    );

    dmem_stage #(.XLEN(32), .DEPTH(DEPTH), .WAIT_STATES(3), .TAG_W(5)) u_dut3 (
        .clk_i(clk), .rstn_i(rstn),
        .req_valid_i(req_valid[1]), .req_ready_o(ready[1]), .req_op_i(op[1]),
        .req_addr_i(addr[1]), .req_wdata_i(wdata[1]), .req_tag_i(tag[1]),
        .flush_i(flush[1]),
        .resp_valid_o(rv[1]), .resp_data_o(rdata[1]), .resp_tag_o(rtag[1]),
        .resp_err_o(rerr[1]), .busy_o(busy[1])
    );

    function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endfunction

    function automatic void check_resp(input int d, input exp_t e);
        check($sformatf("dut%0d tag%0d data", d, e.tag), 64'(rdata[d]), 64'(e.data));
        check($sformatf("dut%0d tag%0d tag", d, e.tag), 64'(rtag[d]), 64'(e.tag));
        check($sformatf("dut%0d tag%0d err", d, e.tag), 64'(rerr[d]), 64'(e.err));
        check($sformatf("dut%0d tag%0d cycle", d, e.tag), 64'(cyc), 64'(e.due));
    endfunction

    // Scoreboard monitors: every response must match the oldest pending expectation
    always @(negedge clk) begin
        if (rstn === 1'b1 && rv[0] === 1'b1) begin
            if (sbq0.size() == 0) begin
                n_cmp++; n_fail++;
                $display("FAIL dut0 unexpected_resp: got response tag %0d, want none", rtag[0]);
            end else begin
                check_resp(0, sbq0.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (rstn === 1'b1 && rv[1] === 1'b1) begin
            if (sbq1.size() == 0) begin
                n_cmp++; n_fail++;
                $display("FAIL dut1 unexpected_resp: got response tag %0d, want none", rtag[1]);
            end else begin
                check_resp(1, sbq1.pop_front());
            end
        end
    end

    // Present a request, wait (bounded) for ready, and record the expected response.
    task automatic issue(input int d, input operation_e o, input logic [31:0] a,
                         input logic [31:0] wd, input logic [4:0] t, input bit exp_resp,
                         input logic [31:0] ed, input logic [1:0] ee);
        int   guard = 0;
        exp_t e;
        @(negedge clk);
        req_valid[d] = 1'b1;
        op[d]        = o;
        addr[d]      = a;
        wdata[d]     = wd;
        tag[d]       = t;
        while (ready[d] !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) begin
            n_cmp++; n_fail++;
            $display("FAIL dut%0d ready_timeout: got ready=%b, want 1", d, ready[d]);
            req_valid[d] = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        if (exp_resp) begin
            e = '{ed, t, ee, cyc + ((d == 0) ? 0 : 3)};
            if (d == 0) sbq0.push_back(e);
            else        sbq1.push_back(e);
        end
    endtask

    initial begin
        int guard;
        rstn = 1'b0;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0;
            flush[d]     = 1'b0;
            op[d]        = OP_LB;
            addr[d]      = '0;
            wdata[d]     = '0;
            tag[d]       = '0;
        end

        tbl[0]  = '{OP_SW,  32'h10, 32'hDEADBEEF, 32'h00000000, 2'b00};
        tbl[1]  = '{OP_LW,  32'h10, 32'h0,        32'hDEADBEEF, 2'b00};
        tbl[2]  = '{OP_SB,  32'h13, 32'h12345680, 32'h00000000, 2'b00};
        tbl[3]  = '{OP_LB,  32'h13, 32'h0,        32'hFFFFFF80, 2'b00};
        tbl[4]  = '{OP_LBU, 32'h13, 32'h0,        32'h00000080, 2'b00};
        tbl[5]  = '{OP_LW,  32'h10, 32'h0,        32'h80ADBEEF, 2'b00};
        tbl[6]  = '{OP_LH,  32'h12, 32'h0,        32'hFFFF80AD, 2'b00};
        tbl[7]  = '{OP_LHU, 32'h12, 32'h0,        32'h000080AD, 2'b00};
        tbl[8]  = '{OP_LB,  32'h10, 32'h0,        32'hFFFFFFEF, 2'b00};
        tbl[9]  = '{OP_SH,  32'h16, 32'hABCD1234, 32'h00000000, 2'b00};
        tbl[10] = '{OP_LH,  32'h16, 32'h0,        32'h00001234, 2'b00};
        tbl[11] = '{operation_e'(4'hF), 32'h10, 32'h0, 32'h00000000, 2'b00};
        tbl[12] = '{OP_SW,  32'h20, 32'hCAFEF00D, 32'h00000000, 2'b00};
        tbl[13] = '{OP_SW,  32'h00, 32'h5A5A5A5A, 32'h00000000, 2'b00};
`ifdef DMEM_ACCESS_CHECK_EN
        tbl[14] = '{OP_SW,  32'h22, 32'h11111111, 32'h00000000, 2'b01};
        tbl[15] = '{OP_LW,  32'h20, 32'h0,        32'hCAFEF00D, 2'b00};
        tbl[16] = '{OP_LW,  DEPTH * 4, 32'h0,     32'h00000000, 2'b10};
        tbl[17] = '{OP_LH,  32'h11, 32'h0,        32'h00000000, 2'b01};
`else
        tbl[14] = '{OP_SW,  32'h22, 32'h11111111, 32'h00000000, 2'b00};
        tbl[15] = '{OP_LW,  32'h20, 32'h0,        32'h11111111, 2'b00};
        tbl[16] = '{OP_LW,  DEPTH * 4, 32'h0,     32'h5A5A5A5A, 2'b00};
        tbl[17] = '{OP_LH,  32'h11, 32'h0,        32'hFFFFBEEF, 2'b00};
`endif

        // Reset values
        #12;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("dut%0d reset ready", d), 64'(ready[d]), 64'd1);
            check($sformatf("dut%0d reset resp_valid", d), 64'(rv[d]), 64'd0);
            check($sformatf("dut%0d reset busy", d), 64'(busy[d]), 64'd0);
            check($sformatf("dut%0d reset data", d), 64'(rdata[d]), 64'd0);
            check($sformatf("dut%0d reset tag", d), 64'(rtag[d]), 64'd0);
            check($sformatf("dut%0d reset err", d), 64'(rerr[d]), 64'd0);
        end
        @(negedge clk);
        rstn = 1'b1;

        // Zero-wait-state instance: back-to-back table vectors
        for (int i = 0; i < NVEC; i++) begin
            issue(0, tbl[i].op, tbl[i].addr, tbl[i].wdata, 5'(i + 1), 1'b1,
                  tbl[i].exp_data, tbl[i].exp_err);
        end
        req_valid[0] = 1'b0;

        // Flush on the accept cycle rejects the request
        flush[0] = 1'b1;
        issue(0, OP_LW, 32'h10, 32'h0, 5'd30, 1'b0, 32'h0, 2'b00);
        req_valid[0] = 1'b0;
        flush[0]     = 1'b0;
        @(negedge clk);
        check("dut0 flush_accept busy", 64'(busy[0]), 64'd0);

        // Three-wait-state instance: build 0x80ADBEEF, then LH with ready/latency checks
        issue(1, OP_SW, 32'h10, 32'hDEADBEEF, 5'd1, 1'b1, 32'h0, 2'b00);
        issue(1, OP_SB, 32'h13, 32'h00000080, 5'd2, 1'b1, 32'h0, 2'b00);
        issue(1, OP_LH, 32'h12, 32'h0,        5'd3, 1'b1, 32'hFFFF80AD, 2'b00);
        req_valid[1] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("dut1 wait%0d ready", k), 64'(ready[1]), 64'd0);
        end
        @(negedge clk);
        check("dut1 resp ready", 64'(ready[1]), 64'd1);
        check("dut1 resp valid", 64'(rv[1]), 64'd1);

        // Flush in the 2nd WAIT cycle drops the store and its response
        issue(1, OP_SW, 32'h20, 32'hCAFE0000, 5'd4, 1'b1, 32'h0, 2'b00);
        issue(1, OP_SW, 32'h20, 32'h00000001, 5'd5, 1'b0, 32'h0, 2'b00);
        req_valid[1] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        flush[1] = 1'b1;
        @(posedge clk);
        #1;
        flush[1] = 1'b0;
        @(negedge clk);
        check("dut1 flush busy", 64'(busy[1]), 64'd0);
        check("dut1 flush ready", 64'(ready[1]), 64'd1);
        issue(1, OP_LW, 32'h20, 32'h0, 5'd6, 1'b1, 32'hCAFE0000, 2'b00);

        // Asynchronous reset in WAIT drops the pending store
        issue(1, OP_SW, 32'h20, 32'h00000077, 5'd7, 1'b0, 32'h0, 2'b00);
        req_valid[1] = 1'b0;
        @(negedge clk);
        check("dut1 pre_reset busy", 64'(busy[1]), 64'd1);
        #2;
        rstn = 1'b0;
        #1;
        check("dut1 async_reset valid", 64'(rv[1]), 64'd0);
        check("dut1 async_reset busy", 64'(busy[1]), 64'd0);
        check("dut1 async_reset ready", 64'(ready[1]), 64'd1);
        check("dut1 async_reset data", 64'(rdata[1]), 64'd0);
        check("dut1 async_reset tag", 64'(rtag[1]), 64'd0);
        check("dut1 async_reset err", 64'(rerr[1]), 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (5) @(negedge clk);
        check("dut1 post_reset busy", 64'(busy[1]), 64'd0);
        issue(1, OP_LW, 32'h20, 32'h0, 5'd8, 1'b1, 32'hCAFE0000, 2'b00);
        req_valid[1] = 1'b0;

        // Drain outstanding expectations
        guard = 0;
        while ((sbq0.size() != 0 || sbq1.size() != 0) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) begin
            n_cmp++; n_fail++;
            $display("FAIL drain: got %0d responses outstanding, want 0", sbq0.size() + sbq1.size());
        end
        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
